// File: rtl/gpu_cmd_pkg.sv
// Shared opcode map, channel indices and default barrier/bypass masks
// for the GPU command dispatcher.
package gpu_cmd_pkg;

    localparam logic [7:0] OP_SWAP   = 8'h01;
    localparam logic [7:0] OP_CLEAR  = 8'h02;
    localparam logic [7:0] OP_STATUS = 8'h07;

    localparam int SWAP_IDX   = 0;
    localparam int CLEAN_IDX  = 1;
    localparam int STATUS_IDX = 7;

    // Swap locks the barrier; status may slip past it.
    localparam logic [7:0] DEF_BARRIER_MASK = 8'b0000_0001;
    localparam logic [7:0] DEF_BYPASS_MASK  = 8'b1000_0000;

    typedef struct packed {
        logic       legal;
        logic [7:0] idx;
    } op_dec_t;

    function automatic op_dec_t opcode_to_idx(input logic [7:0] op);
        op_dec_t d;
        d.legal = 1'b1;
        d.idx   = '0;
        case (op)
            OP_SWAP:                    d.idx = 8'(SWAP_IDX);
            OP_CLEAR:                   d.idx = 8'(CLEAN_IDX);
            8'h03, 8'h04, 8'h05, 8'h06: d.idx = op - 8'h01;
            OP_STATUS:                  d.idx = 8'(STATUS_IDX);
            default:                    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmd_barrier.sv
// Vsync barrier lock: set by a barrier command issue, released on the
// falling edge of vsync. A set in the same cycle as a fall wins.
module cmd_barrier (
    input  logic clk,
    input  logic rst,
    input  logic set_pulse,
    input  logic vsync,
    output logic active
);

    logic vs_d;

    // Track previous vsync level and update the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_d   <= 1'b0;
            active <= 1'b0;
        end else begin
            vs_d <= vsync;
            if (set_pulse)
                active <= 1'b1;
            else if (vs_d && !vsync)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/gpu_cmd_dispatch.sv
// In-order command dispatcher: pops packets from a show-ahead FIFO,
// decodes the opcode, waits for the target engine to go idle, then
// issues a one-cycle strobe with latched argument bytes.
module gpu_cmd_dispatch
    import gpu_cmd_pkg::*;
#(
    parameter int                SIZE         = 256,
    parameter int                OPCODE_BYTE  = 2,
    parameter int                ARG_BYTE     = 3,
    parameter int                ARG_BYTES    = 4,
    parameter int                N_CMD        = 8,
    parameter logic [N_CMD-1:0]  BARRIER_MASK = N_CMD'(DEF_BARRIER_MASK),
    parameter logic [N_CMD-1:0]  BYPASS_MASK  = N_CMD'(DEF_BYPASS_MASK)
) (
    input  logic                   CLK,
    input  logic                   rst,
    input  logic                   fifo_empty,
    input  logic [8*SIZE-1:0]      fifo_data,
    output logic                   rd_en,
    input  logic                   vsync,
    input  logic [N_CMD-1:0]       BUSY,
    output logic [N_CMD-1:0]       cmd_pulse,
    output logic [8*ARG_BYTES-1:0] cmd_args,
    output logic                   barrier_active,
    output logic [7:0]             illegal_cnt
);

    localparam int IDX_W = (N_CMD > 1) ? $clog2(N_CMD) : 1;
    localparam logic [N_CMD-1:0] ONE_HOT = N_CMD'(1);

    typedef enum logic {IDLE, CHECK} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx_q;
    logic                   legal_q;
    logic [8*ARG_BYTES-1:0] args_q;

    op_dec_t                dec;
    logic [IDX_W-1:0]       head_idx;
    logic                   head_legal;
    logic                   barrier_set;
    logic                   blocked;
    logic                   eligible;

    // Head decode and eligibility. The barrier only becomes visible the
    // cycle after the strobe, so a barrier strobe in flight also blocks.
    always_comb begin
        dec         = opcode_to_idx(fifo_data[8*OPCODE_BYTE +: 8]);
        head_idx    = dec.idx[IDX_W-1:0];
        head_legal  = dec.legal && (int'(dec.idx) < N_CMD);
        barrier_set = |(cmd_pulse & BARRIER_MASK);
        blocked     = barrier_active || barrier_set;
        eligible    = !fifo_empty &&
                      (!blocked || (head_legal && BYPASS_MASK[head_idx]));
    end

    // Dispatcher FSM with registered pop, strobe and argument outputs.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state       <= IDLE;
            rd_en       <= 1'b0;
            cmd_pulse   <= '0;
            cmd_args    <= '0;
            illegal_cnt <= '0;
            idx_q       <= '0;
            legal_q     <= 1'b0;
            args_q      <= '0;
        end else begin
            rd_en     <= 1'b0;
            cmd_pulse <= '0;
            case (state)
                IDLE: begin
                    if (eligible) begin
                        rd_en   <= 1'b1;
                        idx_q   <= head_idx;
                        legal_q <= head_legal;
                        args_q  <= fifo_data[8*ARG_BYTE +: 8*ARG_BYTES];
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    if (!legal_q) begin
                        if (illegal_cnt != 8'hFF)
                            illegal_cnt <= illegal_cnt + 8'd1;
                        state <= IDLE;
                    end else if (!BUSY[idx_q]) begin
                        cmd_pulse <= ONE_HOT << idx_q;
                        cmd_args  <= args_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cmd_barrier u_barrier (
        .clk       (CLK),
        .rst       (rst),
        .set_pulse (barrier_set),
        .vsync     (vsync),
        .active    (barrier_active)
    );

endmodule

// File: tb/tb_gpu_cmd_dispatch.sv
// Self-checking bench for gpu_cmd_dispatch: a queue-modelled show-ahead
// FIFO feeds packets, and a scoreboard matches every issue strobe against
// the expected channel and argument word pushed with the packet.
module tb_gpu_cmd_dispatch;

    localparam int SIZE = 256;

    typedef struct {
        logic [7:0]  pulse;
        logic [31:0] args;
    } exp_t;

    logic              CLK;
    logic              rst;
    logic              fifo_empty;
    logic [8*SIZE-1:0] fifo_data;
    logic              rd_en;
    logic              vsync;
    logic [7:0]        BUSY;
    logic [7:0]        cmd_pulse;
    logic [31:0]       cmd_args;
    logic              barrier_active;
    logic [7:0]        illegal_cnt;

    logic [8*SIZE-1:0] pkt_q[$];
    exp_t              exp_q[$];

    int errors;
    int checks;
    int cyc;
    int rd_cnt;
    int pulse_cnt;

    gpu_cmd_dispatch #(
        .SIZE         (SIZE),
        .OPCODE_BYTE  (2),
        .ARG_BYTE     (3),
        .ARG_BYTES    (4),
        .N_CMD        (8),
        .BARRIER_MASK (8'b0000_0001),
        .BYPASS_MASK  (8'b1000_0000)
    ) dut (
        .CLK            (CLK),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_data      (fifo_data),
        .rd_en          (rd_en),
        .vsync          (vsync),
        .BUSY           (BUSY),
        .cmd_pulse      (cmd_pulse),
        .cmd_args       (cmd_args),
        .barrier_active (barrier_active),
        .illegal_cnt    (illegal_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Scoreboard and pop monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (rd_en === 1'b1) begin
            rd_cnt++;
            checks++;
            if (fifo_empty !== 1'b0) begin
                errors++;
                $display("FAIL rd_en_on_empty: fifo_empty=%b required 0", fifo_empty);
            end
        end
        if (cmd_pulse !== 8'h00) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cmd_pulse=%h args=%h required no pulse", cmd_pulse, cmd_args);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cmd_pulse !== e.pulse || cmd_args !== e.args) begin
                    errors++;
                    $display("FAIL scoreboard: pulse=%h args=%h required pulse=%h args=%h",
                             cmd_pulse, cmd_args, e.pulse, e.args);
                end
            end
        end
    end

    function automatic int model_idx(input logic [7:0] op);
        case (op)
            8'h01: return 0;
            8'h02: return 1;
            8'h03: return 2;
            8'h04: return 3;
            8'h05: return 4;
            8'h06: return 5;
            8'h07: return 7;
            default: return -1;
        endcase
    endfunction

    task automatic refresh();
        fifo_empty = (pkt_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : pkt_q[0];
    endtask

    // One clock; the FIFO model pops whatever the DUT strobed this cycle.
    task automatic tick();
        logic pop;
        pop = rd_en;
        @(posedge CLK);
        #1;
        cyc++;
        if (pop === 1'b1 && pkt_q.size() > 0)
            pkt_q.delete(0);
        refresh();
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] args);
        logic [8*SIZE-1:0] pkt;
        exp_t e;
        int   idx;
        pkt           = '0;
        pkt[15:0]     = 16'($urandom);
        pkt[16 +: 8]  = op;
        pkt[24 +: 32] = args;
        pkt[56 +: 32] = $urandom;
        pkt_q.push_back(pkt);
        idx = model_idx(op);
        if (idx >= 0) begin
            e.pulse = 8'h01 << idx;
            e.args  = args;
            exp_q.push_back(e);
        end
        refresh();
    endtask

    task automatic wait_rd(input string name);
        int n;
        n = 0;
        while (rd_en !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (rd_en !== 1'b1) begin
            errors++;
            $display("FAIL %s_rd_timeout: rd_en=%b required 1", name, rd_en);
        end
    endtask

    task automatic wait_pulse(input string name);
        int n;
        n = 0;
        while (cmd_pulse === 8'h00 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_pulse === 8'h00) begin
            errors++;
            $display("FAIL %s_pulse_timeout: cmd_pulse=%h required nonzero", name, cmd_pulse);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((pkt_q.size() != 0 || exp_q.size() != 0) && n < 1000) begin
            tick();
            n++;
        end
        tick();
        tick();
        checks++;
        if (pkt_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: fifo=%0d pending=%0d required 0/0", name, pkt_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 5;
        if (rd_en !== 1'b0)          begin errors++; $display("FAIL reset_rd_en: got %b required 0", rd_en); end
        if (cmd_pulse !== 8'h00)     begin errors++; $display("FAIL reset_pulse: got %h required 00", cmd_pulse); end
        if (cmd_args !== 32'h0)      begin errors++; $display("FAIL reset_args: got %h required 0", cmd_args); end
        if (barrier_active !== 1'b0) begin errors++; $display("FAIL reset_barrier: got %b required 0", barrier_active); end
        if (illegal_cnt !== 8'h00)   begin errors++; $display("FAIL reset_illegal: got %0d required 0", illegal_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_clear();
        int t_rd;
        push(8'h02, 32'hC0DE_335A);
        wait_rd("clear");
        t_rd = cyc;
        tick();
        checks += 3;
        if (cyc != t_rd + 1 || cmd_pulse !== 8'b0000_0010) begin
            errors++;
            $display("FAIL clear_latency: pulse=%h at +%0d required 02 at +1", cmd_pulse, cyc - t_rd);
        end
        if (cmd_args[7:0] !== 8'h5A) begin
            errors++;
            $display("FAIL clear_arg0: got %h required 5a", cmd_args[7:0]);
        end
        if (rd_en !== 1'b0) begin
            errors++;
            $display("FAIL clear_single_pop: rd_en=%b required 0", rd_en);
        end
        drain("clear");
    endtask

    task automatic test_back_to_back();
        int first;
        int last;
        int n;
        first = -1;
        last  = -1;
        push(8'h02, $urandom);
        push(8'h03, $urandom);
        push(8'h05, $urandom);
        push(8'h07, $urandom);
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
            if (cmd_pulse !== 8'h00) begin
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        checks++;
        if (first < 0 || last - first != 6) begin
            errors++;
            $display("FAIL b2b_throughput: span=%0d required 6", last - first);
        end
        drain("b2b");
    endtask

    task automatic test_barrier();
        int r0;
        int cb;
        int n;
        vsync = 1'b1;
        tick();
        tick();
        push(8'h01, 32'h1111_0001);
        push(8'h02, 32'h2222_0002);
        wait_pulse("swap");
        checks++;
        if (cmd_pulse !== 8'h01) begin errors++; $display("FAIL swap_pulse: got %h required 01", cmd_pulse); end
        tick();
        checks++;
        if (barrier_active !== 1'b1) begin errors++; $display("FAIL barrier_set: got %b required 1", barrier_active); end
        r0 = rd_cnt;
        repeat (6) tick();
        checks++;
        if (rd_cnt != r0 || pkt_q.size() != 1) begin
            errors++;
            $display("FAIL barrier_hold: pops=%0d fifo=%0d required 0 pops, 1 queued", rd_cnt - r0, pkt_q.size());
        end
        vsync = 1'b0;
        n = 0;
        while (barrier_active !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        cb = cyc;
        checks++;
        if (barrier_active !== 1'b0) begin errors++; $display("FAIL barrier_release: got %b required 0", barrier_active); end
        wait_pulse("barrier_clear");
        checks++;
        if (cmd_pulse !== 8'h02 || cyc != cb + 2) begin
            errors++;
            $display("FAIL barrier_clear_timing: pulse=%h at +%0d required 02 at +2", cmd_pulse, cyc - cb);
        end
        vsync = 1'b1;
        drain("barrier");
    endtask

    task automatic test_bypass();
        int n;
        push(8'h01, 32'hAAAA_0001);
        n = 0;
        while (barrier_active !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (barrier_active !== 1'b1) begin errors++; $display("FAIL bypass_setup: barrier=%b required 1", barrier_active); end
        push(8'h07, 32'h5555_0007);
        push(8'h02, 32'h6666_0002);
        wait_pulse("bypass");
        checks += 2;
        if (cmd_pulse !== 8'h80) begin errors++; $display("FAIL bypass_pulse: got %h required 80", cmd_pulse); end
        if (barrier_active !== 1'b1) begin errors++; $display("FAIL bypass_keeps_barrier: got %b required 1", barrier_active); end
        repeat (5) tick();
        checks++;
        if (pkt_q.size() != 1) begin errors++; $display("FAIL bypass_clear_waits: fifo=%0d required 1", pkt_q.size()); end
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        drain("bypass");
    endtask

    task automatic test_busy();
        int r0;
        int p0;
        BUSY = 8'h02;
        r0 = rd_cnt;
        push(8'h02, 32'hB0B0_0002);
        wait_rd("busy");
        p0 = pulse_cnt;
        repeat (10) tick();
        checks++;
        if (pulse_cnt != p0) begin errors++; $display("FAIL busy_hold: pulses=%0d required 0", pulse_cnt - p0); end
        BUSY = 8'h00;
        tick();
        checks++;
        if (cmd_pulse !== 8'h02) begin errors++; $display("FAIL busy_release: got %h required 02", cmd_pulse); end
        tick();
        checks++;
        if (rd_cnt - r0 != 1) begin errors++; $display("FAIL busy_single_pop: pops=%0d required 1", rd_cnt - r0); end
        drain("busy");
    endtask

    task automatic test_illegal();
        logic [31:0] args0;
        int r0;
        int p0;
        args0 = cmd_args;
        r0 = rd_cnt;
        p0 = pulse_cnt;
        for (int i = 0; i < 300; i++)
            push(8'h09, $urandom);
        drain("illegal");
        checks += 4;
        if (rd_cnt - r0 != 300) begin errors++; $display("FAIL illegal_pops: got %0d required 300", rd_cnt - r0); end
        if (pulse_cnt != p0)    begin errors++; $display("FAIL illegal_pulses: got %0d required 0", pulse_cnt - p0); end
        if (illegal_cnt !== 8'd255) begin errors++; $display("FAIL illegal_saturate: got %0d required 255", illegal_cnt); end
        if (cmd_args !== args0) begin errors++; $display("FAIL illegal_args: got %h required %h", cmd_args, args0); end
    endtask

    task automatic test_set_vs_fall();
        vsync = 1'b1;
        tick();
        tick();
        push(8'h01, 32'hF00D_0001);
        wait_rd("setfall");
        tick();
        checks++;
        if (cmd_pulse !== 8'h01) begin errors++; $display("FAIL setfall_pulse: got %h required 01", cmd_pulse); end
        vsync = 1'b0;
        tick();
        checks++;
        if (barrier_active !== 1'b1) begin errors++; $display("FAIL setfall_set_wins: got %b required 1", barrier_active); end
        repeat (3) tick();
        checks++;
        if (barrier_active !== 1'b1) begin errors++; $display("FAIL setfall_hold: got %b required 1", barrier_active); end
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        checks++;
        if (barrier_active !== 1'b0) begin errors++; $display("FAIL setfall_next_fall: got %b required 0", barrier_active); end
        drain("setfall");
    endtask

    task automatic test_reset_in_check();
        int p0;
        BUSY = 8'h02;
        push(8'h02, 32'hDEAD_0002);
        wait_rd("rstchk");
        exp_q.delete(exp_q.size() - 1);
        p0 = pulse_cnt;
        rst = 1'b1;
        tick();
        checks += 5;
        if (rd_en !== 1'b0)          begin errors++; $display("FAIL rstchk_rd_en: got %b required 0", rd_en); end
        if (cmd_pulse !== 8'h00)     begin errors++; $display("FAIL rstchk_pulse: got %h required 00", cmd_pulse); end
        if (cmd_args !== 32'h0)      begin errors++; $display("FAIL rstchk_args: got %h required 0", cmd_args); end
        if (barrier_active !== 1'b0) begin errors++; $display("FAIL rstchk_barrier: got %b required 0", barrier_active); end
        if (illegal_cnt !== 8'h00)   begin errors++; $display("FAIL rstchk_illegal: got %0d required 0", illegal_cnt); end
        rst  = 1'b0;
        BUSY = 8'h00;
        repeat (6) tick();
        checks++;
        if (pulse_cnt != p0) begin errors++; $display("FAIL rstchk_no_pulse: pulses=%0d required 0", pulse_cnt - p0); end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        rd_cnt    = 0;
        pulse_cnt = 0;
        rst       = 1'b1;
        vsync     = 1'b1;
        BUSY      = 8'h00;
        refresh();
        test_reset();
        test_single_clear();
        test_back_to_back();
        test_barrier();
        test_bypass();
        test_busy();
        test_illegal();
        test_set_vs_fall();
        test_reset_in_check();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpu_cmd_dispatch.md
# gpu_cmd_dispatch

Parametrised command dispatcher between the packet FIFO and the command engines (swap, clear, status, load, ...). It pops packets in order, decodes the opcode to a command index, and holds issue until that engine's BUSY bit is low. It then emits a one-cycle command pulse with latched argument bytes. It generalises the single swap lock into a configurable vsync barrier set with a bypass set, and counts illegal opcodes.

## Interface
Parameters:
- SIZE, 256 — packet length in bytes; fifo_data is 8*SIZE bits.
- OPCODE_BYTE, 2 — byte index of the opcode in the packet.
- ARG_BYTE, 3 — byte index of the first argument byte.
- ARG_BYTES, 4 — number of argument bytes latched per command.
- N_CMD, 8 — number of command channels; width of BUSY and cmd_pulse.
- BARRIER_MASK, 8'b0000_0001 — channels whose issue sets the vsync barrier.
- BYPASS_MASK, 8'b1000_0000 — channels allowed past an active barrier.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- CLK, in, 1 — system clock.
- rst, in, 1 — synchronous active-high reset.
- fifo_empty, in, 1 — packet FIFO empty flag.
- fifo_data, in, 8*SIZE — show-ahead head of the FIFO; valid while !fifo_empty.
- rd_en, out, 1 — one-cycle pop.
- vsync, in, 1 — VGA VS level.
- BUSY, in, N_CMD — per-engine busy flags.
- cmd_pulse, out, N_CMD — one-hot, one-cycle issue strobe.
- cmd_args, out, 8*ARG_BYTES — arguments of the last issued command.
- barrier_active, out, 1 — barrier lock state.
- illegal_cnt, out, 8 — saturating count of dropped illegal opcodes.

## Operation
- Opcode map, via gpu_cmd_pkg::opcode_to_idx:
  - 0x01 → 0 (swap)
  - 0x02 → 1 (clear)
  - 0x03..0x06 → 2..5
  - 0x07 → 7 (status)
  - Any other value, or any index ≥ N_CMD, is illegal.
- FSM states: IDLE, CHECK.
- IDLE:
  - The head is eligible when !fifo_empty and either !barrier_active or BYPASS_MASK[idx(head)] = 1. Illegal opcodes are never bypass.
  - On an eligible head: assert rd_en, capture the opcode, index and ARG_BYTES bytes starting at ARG_BYTE, then go to CHECK.
- CHECK:
  - Illegal opcode: increment illegal_cnt (saturating at 255), no pulse, go to IDLE.
  - BUSY[idx] = 1: stay in CHECK. No timeout; the FIFO is not popped.
  - Otherwise: set cmd_pulse[idx] = 1 for one cycle and load cmd_args. If BARRIER_MASK[idx], set the barrier. Go to IDLE.
- Packets issue strictly in FIFO order; a bypass only applies when the bypass packet is at the head.
- Barrier clears on the vsync falling edge (vs_d & ~vsync).
- Barrier set and vsync fall in the same cycle: set wins, and the barrier holds until the next fall.
- cmd_args holds its value between issues; an illegal packet does not modify it.

## Timing
- Reset values: rd_en 0, cmd_pulse 0, cmd_args 0, barrier_active 0, illegal_cnt 0, state IDLE, vs_d 0. vs_d = 0 means no false edge is detected on the first cycle.
- Latency: eligible head at cycle t → rd_en at t → cmd_pulse at t+1 when the engine is idle.
- Throughput: one command per 2 cycles.
- cmd_args is valid in the same cycle as cmd_pulse.
- barrier_active rises the cycle after the barrier command's pulse. It falls the cycle after the vsync falling edge.
- rd_en is never asserted while fifo_empty = 1.
- Reset mid-operation: a packet already popped and held in CHECK is discarded.
- BUSY is sampled only in CHECK; BUSY changes during IDLE have no effect.

## Structure
- Package gpu_cmd_pkg:
  - opcode constants OP_SWAP, OP_CLEAR, OP_STATUS
  - index constants SWAP_IDX, CLEAN_IDX, STATUS_IDX
  - function opcode_to_idx returning {legal, idx}
  - default masks
- Sub-module cmd_barrier: vsync edge detect plus lock register, with inputs set_pulse and vsync and output active. The dispatcher FSM lives in the top module.

## Test plan
- Clear packet (opcode 0x02, arg0 0x5A), BUSY = 0: rd_en at t, cmd_pulse = 8'b0000_0010 at t+1, cmd_args[7:0] = 0x5A.
- Swap then clear queued: swap pulse issues and barrier_active = 1. Clear is held with no rd_en until the vsync falling edge; its pulse arrives 2 cycles after the barrier clears.
- Barrier active, status (0x07) at head: status is popped and cmd_pulse[7] = 1 with no vsync edge. A following clear still waits.
- BUSY[1] = 1 for 10 cycles with a clear in CHECK: no pulse for 10 cycles, pulse on the cycle after BUSY falls, exactly one rd_en.
- 300 packets with opcode 0x09: 300 rd_en, no pulses, illegal_cnt saturates at 255, cmd_args unchanged.
- Swap issued in the same cycle as a vsync fall: barrier stays set until the next fall. Then assert rst while in CHECK: all outputs return to reset values and no pulse occurs.
